// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction and data requesters, data first; grant edge
// then ram_rdy cycle (min 2 cycles); optional ARB_STARVE_GUARD_EN lets iREN win after STREAK_MAX data grants.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STREAK_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   input  logic              ram_rdy,
   input  logic [DATA_W-1:0] ramload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   output logic              iwait,
   output logic              dwait,
   output logic [DATA_W-1:0] iload,
   output logic [DATA_W-1:0] dload
);

   typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

   state_t state_q, state_d;
   logic   d_req;
   logic   i_done;
   logic   d_done;
   logic   guard;

   assign d_req  = dREN | dWEN;
   assign i_done = (state_q == IGNT) & ram_rdy;
   assign d_done = (state_q == DGNT) & ram_rdy;

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STREAK_MAX + 1);
   logic [SW-1:0] streak_q, streak_d;

   assign guard = iREN & (streak_q == SW'(STREAK_MAX));

   always_comb begin
      streak_d = streak_q;
      if (!iREN || i_done)
         streak_d = '0;
      else if (d_done && streak_q != SW'(STREAK_MAX))
         streak_d = streak_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) streak_q <= '0;
      else       streak_q <= streak_d;
   end
`else
   assign guard = 1'b0;
`endif

   // A grant ends on completion or when its owner withdraws the request (abort).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (d_req && !guard) state_d = DGNT;
            else if (iREN)       state_d = IGNT;
         end
         IGNT:    if (ram_rdy || !iREN)  state_d = IDLE;
         DGNT:    if (ram_rdy || !d_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = iREN;
      dwait    = d_req;
      iload    = '0;
      dload    = '0;
      case (state_q)
         IGNT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            iwait   = iREN & ~ram_rdy;
            if (ram_rdy) iload = ramload;
         end
         DGNT: begin
            // A simultaneous read and write is serviced as a write.
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dwait    = d_req & ~ram_rdy;
            if (ram_rdy) dload = ramload;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vectors through a scoreboard queue, then the starvation-guard sequence.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        nRST, iREN, dREN, dWEN, ram_rdy;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic        ramREN, ramWEN, iwait, dwait;
   logic [31:0] ramaddr, ramstore, iload, dload;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   mem_arbiter dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .ram_rdy(ram_rdy), .ramload(ramload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload)
   );

   typedef struct packed {
      logic        ren, wen;
      logic [31:0] addr, store;
      logic        iw, dw;
      logic [31:0] il, dl;
   } exp_t;

   typedef struct packed {
      logic        nrst, iren, dren, dwen, rdy;
      logic [31:0] iaddr, daddr, dstore, ramload;
      exp_t        e;
   } vec_t;

   vec_t vt[$];
   exp_t sb[$];

   function automatic vec_t v(input logic nr, ir, dr, dw_, rd,
                              input logic [31:0] ia, da, ds, rl,
                              input logic ren, wen, input logic [31:0] ad, st,
                              input logic iw, dw, input logic [31:0] il, dl);
      vec_t r;
      r.nrst = nr; r.iren = ir; r.dren = dr; r.dwen = dw_; r.rdy = rd;
      r.iaddr = ia; r.daddr = da; r.dstore = ds; r.ramload = rl;
      r.e.ren = ren; r.e.wen = wen; r.e.addr = ad; r.e.store = st;
      r.e.iw = iw; r.e.dw = dw; r.e.il = il; r.e.dl = dl;
      return r;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      iREN = 0; dREN = 0; dWEN = 0; ram_rdy = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
   endtask

   int dn, ig, first_i_at_dn;

   initial begin
      nRST = 0;
      drive_idle();
      iREN = 1; dREN = 1;
      @(posedge CLK); #1;

      // nrst ir dr dw rdy | iaddr daddr dstore ramload | ren wen addr store iw dw iload dload
      vt.push_back(v(0,1,1,0,0, 0,0,0,0,                   0,0,0,0,1,1,0,0));
      vt.push_back(v(0,1,1,0,0, 0,0,0,0,                   0,0,0,0,1,1,0,0));
      vt.push_back(v(1,0,0,0,0, 0,0,0,0,                   0,0,0,0,0,0,0,0));
      vt.push_back(v(1,1,0,0,0, 32'h40,0,0,0,              0,0,0,0,1,0,0,0));
      vt.push_back(v(1,1,0,0,0, 32'h40,0,0,0,              1,0,32'h40,0,1,0,0,0));
      vt.push_back(v(1,1,0,0,1, 32'h40,0,0,32'hDEADBEEF,   1,0,32'h40,0,0,0,32'hDEADBEEF,0));
      vt.push_back(v(1,0,0,0,1, 0,0,0,32'h11111111,        0,0,0,0,0,0,0,0));
      vt.push_back(v(1,1,1,1,0, 32'h44,32'h80,32'h1234,0,  0,0,0,0,1,1,0,0));
      vt.push_back(v(1,1,1,1,0, 32'h44,32'h80,32'h1234,0,  0,1,32'h80,32'h1234,1,1,0,0));
      vt.push_back(v(1,1,1,1,1, 32'h44,32'h80,32'h1234,32'h5555, 0,1,32'h80,32'h1234,1,0,0,32'h5555));
      vt.push_back(v(1,1,0,0,0, 32'h44,0,0,0,              0,0,0,0,1,0,0,0));
      vt.push_back(v(1,1,0,0,1, 32'h44,0,0,32'hCAFEF00D,   1,0,32'h44,0,0,0,32'hCAFEF00D,0));
      vt.push_back(v(1,0,1,0,0, 0,32'h90,0,0,              0,0,0,0,0,1,0,0));
      vt.push_back(v(1,0,1,0,0, 0,32'h90,0,0,              1,0,32'h90,0,0,1,0,0));
      vt.push_back(v(1,0,0,0,0, 0,32'h90,0,0,              0,0,32'h90,0,0,0,0,0));
      vt.push_back(v(1,0,0,0,0, 0,0,0,0,                   0,0,0,0,0,0,0,0));
      vt.push_back(v(1,0,1,0,1, 0,32'hA0,0,32'h77,         0,0,0,0,0,1,0,0));
      vt.push_back(v(0,0,1,0,0, 0,32'hA0,0,0,              1,0,32'hA0,0,0,1,0,0));
      vt.push_back(v(1,0,1,0,0, 0,32'hA0,0,0,              0,0,0,0,0,1,0,0));
      vt.push_back(v(1,0,0,0,0, 0,32'hA0,0,0,              0,0,32'hA0,0,0,0,0,0));
      vt.push_back(v(1,0,0,0,0, 0,0,0,0,                   0,0,0,0,0,0,0,0));

      for (int i = 0; i < vt.size(); i++) begin
         exp_t e;
         nRST = vt[i].nrst; iREN = vt[i].iren; dREN = vt[i].dren; dWEN = vt[i].dwen;
         ram_rdy = vt[i].rdy; iaddr = vt[i].iaddr; daddr = vt[i].daddr;
         dstore = vt[i].dstore; ramload = vt[i].ramload;
         sb.push_back(vt[i].e);
         @(negedge CLK);
         e = sb.pop_front();
         check("ramREN",   i, {31'd0, ramREN}, {31'd0, e.ren});
         check("ramWEN",   i, {31'd0, ramWEN}, {31'd0, e.wen});
         check("ramaddr",  i, ramaddr,  e.addr);
         check("ramstore", i, ramstore, e.store);
         check("iwait",    i, {31'd0, iwait},  {31'd0, e.iw});
         check("dwait",    i, {31'd0, dwait},  {31'd0, e.dw});
         check("iload",    i, iload, e.il);
         check("dload",    i, dload, e.dl);
         @(posedge CLK); #1;
      end

      // Starvation: iREN held, data request always pending, RAM always ready.
      nRST = 0; drive_idle();
      @(posedge CLK); #1;
      nRST = 1; iREN = 1; dREN = 1; ram_rdy = 1; iaddr = 32'h100; daddr = 32'h200; ramload = 32'h9;
      dn = 0; ig = 0; first_i_at_dn = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (dREN && !dwait) dn++;
         if (iREN && !iwait) begin
            if (ig == 0) first_i_at_dn = dn;
            ig++;
         end
         @(posedge CLK); #1;
      end
`ifdef ARB_STARVE_GUARD_EN
      check("data_before_first_igrant", 0, first_i_at_dn, 4);
      check("igrant_occurred", 0, {31'd0, ig > 0}, 32'd1);
`else
      check("igrant_count", 0, ig, 0);
      check("data_completions", 0, dn, 20);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
